// File: rtl/axi_init_pkg.sv
// axi_init_pkg: shared types and constants for the display-memory bus initiator
package axi_init_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int TIMEOUT_DEF = 15;
  localparam logic OP_READ = 1'b0;
  localparam logic OP_WRITE = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_AR, S_RD, S_CAP, S_WA, S_AW, S_WD, S_RSP} state_e;
endpackage

// File: rtl/axi_init_wdog.sv
// axi_init_wdog: per-command cycle watchdog, expires on the cycle the count would reach the limit
module axi_init_wdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [3:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? 4'd0 : en ? cnt_q + 4'd1 : cnt_q;
  assign expired = en && cnt_q == 4'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) cnt_q <= rst ? 4'd0 : cnt_d;
endmodule

// File: rtl/axi_initiator.sv
// axi_initiator: single-command read/copy-write master for the display-memory bus
module axi_initiator
  import axi_init_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_src,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              ms_arvalid,
  output logic [ADDR_W-1:0] SWM_arADDR,
  output logic              ms_rready,
  input  logic              sm_arready,
  input  logic              sm_rvalid,
  input  logic [DATA_W-1:0] disp_hex_r,
  output logic              ms_awvalid,
  output logic              ms_wvalid,
  output logic [ADDR_W-1:0] SWM_wdata,
  input  logic              sm_awready,
  input  logic              sm_wready
);
  state_e state_q, state_d;
  logic accept, stall, err_d, wd_en, wd_clr, wd_expired;
  logic write_q, write_d;
  logic cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic busy_q, busy_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d, src_q, src_d;

  assign wd_clr = state_q == S_IDLE;
  assign wd_en = !(state_q inside {S_IDLE, S_RSP});

  axi_init_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk    (clk),
    .rst    (reset),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_expired)
  );

  always_comb begin
    accept = cmd_valid && cmd_ready_q;
    state_d = state_q;
    err_d = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = cmd_write == OP_READ ? S_AR : (cmd_addr == '0 ? S_RSP : S_WA);
        err_d = cmd_write == OP_WRITE && cmd_addr == '0;
      end
      S_AR:  if (sm_arready) state_d = S_RD;
      S_RD:  if (sm_rvalid) state_d = S_CAP;
      S_CAP: state_d = S_RSP;
      S_WA:  state_d = S_AW;
      S_AW:  if (sm_awready) state_d = S_WD;
      S_WD:  if (sm_wready) state_d = S_RSP;
      default: state_d = S_IDLE;
    endcase
    // a handshake that advances the FSM beats a simultaneous expiry
    stall = state_d == state_q;
    if (wd_expired && stall) begin
      state_d = S_RSP;
      err_d = 1'b1;
    end
    write_d = accept ? cmd_write : write_q;
    addr_d = accept ? cmd_addr : (state_d == S_IDLE ? '0 : addr_q);
    src_d = accept ? cmd_src : (state_d == S_IDLE ? '0 : src_q);
    cmd_ready_d = state_d == S_IDLE;
    busy_d = state_d != S_IDLE;
    rsp_valid_d = state_d == S_RSP;
    rsp_err_d = state_d == S_RSP && err_d;
    rsp_data_d = state_d == S_RSP ? (state_q == S_CAP && write_q == OP_READ ? disp_hex_r : '0) : rsp_data_q;
    arvalid_d = state_d inside {S_AR, S_RD, S_WA};
    rready_d = state_d == S_RD;
    awvalid_d = state_d inside {S_AW, S_WD};
    wvalid_d = state_d == S_WD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q <= '0;
      src_q <= '0;
      cmd_ready_q <= 1'b0;
      busy_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_data_q <= '0;
      arvalid_q <= 1'b0;
      rready_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q <= addr_d;
      src_q <= src_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
      arvalid_q <= arvalid_d;
      rready_q <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err = rsp_err_q;
  assign rsp_data = rsp_data_q;
  assign ms_arvalid = arvalid_q;
  assign ms_rready = rready_q;
  assign ms_awvalid = awvalid_q;
  assign ms_wvalid = wvalid_q;
  assign SWM_arADDR = addr_q;
  assign SWM_wdata = src_q;
endmodule

// File: tb/tb_axi_initiator.sv
// tb_axi_initiator: randomized scoreboard bench with a memory/7-segment responder and command-level model
module tb_axi_initiator;
  localparam int TO = 15;
  localparam logic [6:0] SEG [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                      7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [3:0] cmd_addr = '0, cmd_src = '0;
  logic cmd_ready, rsp_valid, rsp_err, busy;
  logic [7:0] rsp_data, disp_hex_r;
  logic ms_arvalid, ms_rready, ms_awvalid, ms_wvalid;
  logic [3:0] SWM_arADDR, SWM_wdata;
  logic sm_arready = 1'b0, sm_rvalid = 1'b0, sm_awready = 1'b0, sm_wready;
  logic rvalid_en = 1'b1;
  logic [3:0] rmem [16];
  logic [3:0] raddr = '0;

  int cyc = 0, checks = 0, failures = 0, n_push = 0, n_rsp = 0, aw_cnt = 0, t_last = 0;
  bit mon_on = 1'b0;
  logic [7:0] last_data = '0;
  logic [3:0] mdl [16];

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat;
    int         t0;
  } exp_t;
  exp_t exp_q[$];

  axi_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_src(cmd_src),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .ms_arvalid(ms_arvalid), .SWM_arADDR(SWM_arADDR), .ms_rready(ms_rready),
    .sm_arready(sm_arready), .sm_rvalid(sm_rvalid), .disp_hex_r(disp_hex_r),
    .ms_awvalid(ms_awvalid), .ms_wvalid(ms_wvalid), .SWM_wdata(SWM_wdata),
    .sm_awready(sm_awready), .sm_wready(sm_wready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // responder: one-cycle-late arready/rvalid/awready, wready follows wvalid
  initial for (int i = 0; i < 16; i++) rmem[i] = 4'(i);
  assign sm_wready = ms_wvalid;
  assign disp_hex_r = {SEG[rmem[raddr]], 1'b1};
  always @(posedge clk) begin
    if (ms_arvalid) raddr <= SWM_arADDR;
    sm_arready <= ms_arvalid && !sm_arready && !ms_rready;
    sm_rvalid <= ms_rready && !sm_rvalid && rvalid_en;
    sm_awready <= ms_awvalid && !sm_awready && !ms_wvalid && raddr != 4'd0;
    if (ms_wvalid && sm_wready) rmem[raddr] <= rmem[SWM_wdata];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic model(input logic w, input logic [3:0] a, input logic [3:0] s, input bit tmo, output int lat);
    exp_t e;
    e.t0 = cyc;
    if (!w) begin
      e.data = tmo ? 8'h00 : {SEG[mdl[a]], 1'b1};
      e.err = tmo;
      e.lat = tmo ? TO + 1 : 6;
    end else if (a == 4'd0) begin
      e.data = 8'h00;
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      mdl[a] = mdl[s];
      e.data = 8'h00;
      e.err = 1'b0;
      e.lat = 5;
    end
    lat = e.lat;
    exp_q.push_back(e);
    n_push++;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
  endtask

  task automatic issue(input logic w, input logic [3:0] a, input logic [3:0] s, input bit push, input bit tmo);
    int l;
    wait_ready();
    rvalid_en = !tmo;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_src = s;
    t_last = cyc;
    if (push) model(w, a, s, tmo, l);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) last_data <= '0;
    else if (mon_on) begin
      if (ms_awvalid) aw_cnt <= aw_cnt + 1;
      if (rsp_valid) begin
        n_rsp <= n_rsp + 1;
        chk("rsp_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_latency", cyc - e.t0, e.lat);
        end
        last_data <= rsp_data;
      end else chk("rsp_data_hold", rsp_data, last_data);
    end
  end

  initial begin
    logic w;
    logic [3:0] a, s;
    bit tmo;
    int a0, l, nxt_rdy, n;
    for (int i = 0; i < 16; i++) mdl[i] = 4'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_handshake", {cmd_ready, rsp_valid, rsp_err, busy}, 4'b0000);
    chk("reset_rsp_data", rsp_data, 8'h00);
    chk("reset_bus", {ms_arvalid, ms_rready, ms_awvalid, ms_wvalid}, 4'b0000);
    chk("reset_addr", {SWM_arADDR, SWM_wdata}, 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", {cmd_ready, busy}, 2'b10);
    mon_on = 1'b1;

    issue(1'b0, 4'd3, 4'd0, 1'b1, 1'b0);
    issue(1'b1, 4'd5, 4'd2, 1'b1, 1'b0);
    issue(1'b0, 4'd5, 4'd0, 1'b1, 1'b0);

    wait_ready();
    a0 = aw_cnt;
    issue(1'b1, 4'd0, 4'd7, 1'b1, 1'b0);
    wait_ready();
    repeat (2) begin @(posedge clk); #1; end
    chk("awvalid_on_addr0", aw_cnt - a0, 0);

    issue(1'b0, 4'd1, 4'd0, 1'b1, 1'b1);
    wait_ready();
    chk("timeout_ready_cycle", cyc - t_last, TO + 2);

    // self-copy write so the responder's memory is unchanged whatever the abort edge does
    issue(1'b1, 4'd6, 4'd6, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("in_wd", {ms_awvalid, ms_wvalid}, 2'b11);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_outputs", {ms_arvalid, ms_rready, ms_awvalid, ms_wvalid, rsp_valid, busy, cmd_ready}, 7'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", cmd_ready, 1'b1);
    issue(1'b0, 4'd9, 4'd0, 1'b1, 1'b0);

    repeat (40) begin
      w = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      s = 4'($urandom_range(0, 15));
      tmo = !w && $urandom_range(0, 5) == 0;
      issue(w, a, s, 1'b1, tmo);
    end

    wait_ready();
    rvalid_en = 1'b1;
    nxt_rdy = cyc;
    cmd_valid = 1'b1;
    repeat (80) begin
      chk("ready_schedule", cmd_ready, cyc >= nxt_rdy);
      w = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      s = 4'($urandom_range(0, 15));
      cmd_write = w;
      cmd_addr = a;
      cmd_src = s;
      if (cmd_ready) begin
        model(w, a, s, 1'b0, l);
        nxt_rdy = cyc + l + 1;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("rsp_count", n_rsp, n_push);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_initiator.md
# axi_initiator

Master-side driver for the team's 4-bit-address display-memory bus. It accepts one read or copy-write command at a time from the board-level controller, sequences the address, read and write channels into the memory/7-segment responder, and returns the responder's 8-bit display byte or a write acknowledgement. A watchdog guarantees the block never hangs on a silent responder.

## Interface
- `TIMEOUT_CYCLES`, default 15: per-command wait limit in cycles, counted from leaving IDLE; must be ≥ 8.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE; a command is accepted on `cmd_valid && cmd_ready`.
- `cmd_write` in 1: 0 = read, 1 = copy-write.
- `cmd_addr` in 4: read address, or destination address for a write.
- `cmd_src` in 4: source index for a write (`mem[cmd_addr] <= mem[cmd_src]`); ignored on reads.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out 8: display byte on a read; 0 on a write or an error; held until the next `rsp_valid`.
- `rsp_err` out 1: qualifies `rsp_valid`; 1 = timeout or illegal command.
- `busy` out 1: high whenever not in IDLE.
- `ms_arvalid` out 1, `SWM_arADDR` out 4, `ms_rready` out 1: address and read channel.
- `sm_arready` in 1, `sm_rvalid` in 1, `disp_hex_r` in 8: responder read side.
- `ms_awvalid` out 1, `ms_wvalid` out 1, `SWM_wdata` out 4: write channel.
- `sm_awready` in 1, `sm_wready` in 1: responder write side.

## Operation
- On acceptance, latch `cmd_addr`, `cmd_src` and `cmd_write`. `SWM_arADDR` and `SWM_wdata` drive the latched values for the whole command, and 0 in IDLE.
- States: IDLE, AR, RD, CAP, WA, AW, WD, RSP.
- **Read sequence**
  - IDLE → AR: `ms_arvalid`=1, `ms_rready`=0. Stay in AR for at least 1 cycle, so the responder latches the address, and until `sm_arready`=1.
  - AR → RD: `ms_arvalid`=1, `ms_rready`=1. Wait for `sm_rvalid`=1.
  - RD → CAP on the edge where `sm_rvalid` is sampled high. In CAP, `ms_arvalid`=0 and `ms_rready`=0, and the block captures `disp_hex_r` into `rsp_data`.
  - CAP → RSP.
- **Write sequence**
  - If `cmd_addr`==0, go IDLE → RSP with `rsp_err`=1. The responder never raises `sm_awready` for address 0.
  - Otherwise IDLE → WA: `ms_arvalid`=1 for exactly 1 cycle, which latches the destination address in the responder.
  - WA → AW: `ms_awvalid`=1. Wait for `sm_awready`.
  - AW → WD: `ms_awvalid`=1, `ms_wvalid`=1. Wait for `sm_wready`.
  - WD → RSP.
- **RSP**: one cycle with `rsp_valid`=1. All bus valids and readies are 0. Next state is IDLE.
- **Watchdog**: a 4-bit counter clears in IDLE and increments in every other state except RSP. When it reaches `TIMEOUT_CYCLES`, go to RSP with `rsp_err`=1 and `rsp_data`=0, whatever the current state.
- `cmd_valid` while busy is ignored; there is no queueing.

## Timing
- Reset values: every output is 0, state is IDLE, the counter is 0. `cmd_ready` is 1 from the first cycle after reset deasserts.
- Reset asserted mid-command forces IDLE on the next edge and drops all valids and readies in that same edge. No `rsp_valid` is produced for the aborted command.
- Against the reference responder:
  - Read: 6 cycles from acceptance to `rsp_valid` (accept, AR×2, RD×2, CAP).
  - Write: 5 cycles from acceptance to `rsp_valid`.
  - Back-to-back commands: at most one command every (latency + 1) cycles.
- `rsp_valid` is exactly 1 cycle per accepted command, never 0 and never 2.
- Simultaneous timeout and handshake in the same cycle: the handshake wins.

## Structure
- Package `axi_init_pkg` holds:
  - the state enum;
  - the opcode constants `OP_READ`/`OP_WRITE`;
  - `ADDR_W`=4 and `DATA_W`=8;
  - the default timeout.
- One sub-module, `axi_init_wdog`: a counter with `clr`, `en` and `expired` outputs, parameterised on `TIMEOUT_CYCLES`. It is instantiated once.
- FSM and datapath stay in `axi_initiator`. Expected size is about 200 RTL lines.

## Test plan
- Reset, then a read at addr 3 against the responder model (memory initialised to mem[i]=i): `rsp_valid` pulses 6 cycles after acceptance with `rsp_data`=0x0D and `rsp_err`=0.
- Write with addr 5, src 2, then a read at addr 5: write `rsp_valid` with `rsp_err`=0; the read returns 0x25.
- Write with addr 0: `rsp_valid` with `rsp_err`=1 one cycle after acceptance, and `ms_awvalid` is never asserted.
- Responder with `sm_rvalid` tied low, read at addr 1: `rsp_err`=1 and `rsp_data`=0 after 15 busy cycles, then `cmd_ready`=1.
- Assert `reset` during WD: all bus outputs are 0 the next cycle, there is no `rsp_valid`, and a following read at addr 9 returns 0x09.
- Hold `cmd_valid` high continuously: commands are accepted only when `cmd_ready`=1, with exactly one `rsp_valid` per acceptance.
